// File: rtl/div_sgn_seq.sv
// Sequential signed divider: recovers X = P / Y one quotient bit per cycle.
// Radix-2 restoring division on magnitudes, with signs and range fixed up afterwards.
module div_sgn_seq #(
  parameter int BW     = 8,
  parameter int widthX = BW,
  parameter int widthY = BW
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [widthX+widthY-1:0] P,
  input  logic signed [widthY-1:0]        Y,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [widthX-1:0]        Q,
  output logic signed [widthY-1:0]        R,
  output logic                            DZ,
  output logic                            OV
);

  localparam int WP = widthX + widthY;
  localparam int CW = (widthX > 1) ? $clog2(widthX) : 1;
  localparam logic [widthX-1:0] HALF = {1'b1, {(widthX-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} st_t;

  st_t st, st_n;

  logic [WP-1:0]     pu, pabs;
  logic [widthY-1:0] yu, yabs;
  logic              acc, yz, eov;

  logic [widthY-1:0] rem, ym;
  logic [widthX-1:0] qm;
  logic [CW-1:0]     cnt;
  logic              sp, sy;

  logic [widthY:0]   t, nrem;
  logic              ge;
  logic [widthX-1:0] qs;
  logic [widthY-1:0] rs;
  logic              qneg, ovf;

  assign pu   = P;
  assign yu   = Y;
  assign pabs = pu[WP-1] ? ('0 - pu) : pu;
  assign yabs = yu[widthY-1] ? ('0 - yu) : yu;
  assign acc  = in_valid & in_ready;
  assign yz   = (yu == '0);
  // quotient magnitude needs more than widthX bits
  assign eov  = pabs[WP-1:widthX] >= yabs;

  assign t    = {rem, qm[widthX-1]};
  assign ge   = t >= {1'b0, ym};
  assign nrem = ge ? (t - {1'b0, ym}) : t;

  assign qneg = sp ^ sy;
  assign qs   = qneg ? ('0 - qm) : qm;
  assign rs   = sp ? ('0 - rem) : rem;
  assign ovf  = qneg ? (qm > HALF) : (qm >= HALF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st <= IDLE;
    else       st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE: if (acc) st_n = (yz || eov) ? DONE : CALC;
      CALC: if (cnt == '0) st_n = FIX;
      FIX:  st_n = DONE;
      DONE: if (out_ready) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem <= '0;
      ym  <= '0;
      qm  <= '0;
      cnt <= '0;
      sp  <= 1'b0;
      sy  <= 1'b0;
      Q   <= '0;
      R   <= '0;
      DZ  <= 1'b0;
      OV  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: if (acc) begin
          ym  <= yabs;
          sp  <= pu[WP-1];
          sy  <= yu[widthY-1];
          rem <= pabs[WP-1:widthX];
          qm  <= pabs[widthX-1:0];
          cnt <= CW'(widthX-1);
          if (yz) begin
            DZ <= 1'b1;
            OV <= 1'b0;
            Q  <= '1;
            R  <= pu[widthY-1:0];
          end else if (eov) begin
            DZ <= 1'b0;
            OV <= 1'b1;
            Q  <= '0;
            R  <= '0;
          end else begin
            DZ <= 1'b0;
            OV <= 1'b0;
          end
        end
        CALC: begin
          rem <= nrem[widthY-1:0];
          qm  <= {qm[widthX-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          DZ <= 1'b0;
          if (ovf) begin
            OV <= 1'b1;
            Q  <= '0;
            R  <= '0;
          end else begin
            OV <= 1'b0;
            Q  <= qs;
            R  <= rs;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sgn_seq.sv
// Bench for div_sgn_seq: directed cases, backpressure, mid-op reset,
// then random operands against an integer-division reference.
module tb_div_sgn_seq;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid, DZ, OV;
  logic signed [15:0] P = '0;
  logic signed [7:0]  Y = '0;
  logic signed [7:0]  Q, R;

  int nchk = 0;
  int nerr = 0;

  div_sgn_seq #(.BW(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .Y(Y),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .DZ(DZ), .OV(OV)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input int p, input int y, input int hold);
    int eq, er, edz, eov, elat, n, ap, ay, q;
    ap = (p < 0) ? -p : p;
    ay = (y < 0) ? -y : y;
    edz = 0; eov = 0;
    if (y == 0) begin
      edz = 1; eq = -1;
      er = ((p & 255) ^ 128) - 128;
      elat = 1;
    end else begin
      q = p / y;
      elat = (ap / 256 >= ay) ? 1 : 10;
      if (q > 127 || q < -128) begin
        eov = 1; eq = 0; er = 0;
      end else begin
        eq = q; er = p % y;
      end
    end
    @(negedge clk_i);
    chk("idle_rdy", int'(in_ready), 1);
    P = 16'(p); Y = 8'(y); in_valid = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid = 1'b0; P = 16'($urandom); Y = 8'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("latency", n, elat);
    chk("Q", int'(Q), eq);
    chk("R", int'(R), er);
    chk("DZ", int'(DZ), edz);
    chk("OV", int'(OV), eov);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 0);
      P = 16'($urandom); Y = 8'($urandom);
      @(negedge clk_i);
      chk("hold_v", int'(out_valid), 1);
      chk("hold_rdy", int'(in_ready), 0);
      chk("hold_Q", int'(Q), eq);
      chk("hold_R", int'(R), er);
      chk("hold_fl", int'({DZ, OV}), edz * 2 + eov);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk_i);
    out_ready = 1'b0;
    chk("rel_v", int'(out_valid), 0);
    chk("rel_rdy", int'(in_ready), 1);
  endtask

  initial begin
    int seen, p, y;
    #2 rst_i = 1'b1;
    #1;
    chk("rst_v", int'(out_valid), 0);
    chk("rst_rdy", int'(in_ready), 1);
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_fl", int'({DZ, OV}), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op(-15, 4, 0);
    run_op(100, -7, 0);
    run_op(-128, 1, 0);
    run_op(128, 1, 0);
    run_op(-32768, 1, 0);
    run_op(1234, 0, 0);
    run_op(-32768, -128, 0);
    run_op(32767, 127, 0);
    run_op(777, -3, 5);
    run_op(-1000, 9, 5);
    run_op(5, 0, 3);

    @(negedge clk_i);
    P = 16'(1000); Y = 8'(3); in_valid = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_v", int'(out_valid), 0);
    chk("mid_rst_rdy", int'(in_ready), 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    repeat (14) begin
      @(negedge clk_i);
      if (out_valid) seen++;
    end
    chk("no_stale", seen, 0);
    run_op(-32767, -128, 0);

    for (int k = 0; k < 40; k++) begin
      y = int'($urandom_range(0, 255)) - 128;
      if (k % 3 == 0) p = int'($urandom_range(0, 65535)) - 32768;
      else            p = int'($urandom_range(0, 8000)) - 4000;
      run_op(p, y, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
